// File: rtl/mem_master.sv
// Datapath-to-memory load/store master with sub-word extraction, read-modify-write and error reporting.
// Latency: error 1 cycle, load or word store WAIT_CYCLES+1, sub-word store 2*WAIT_CYCLES+1; one request in flight.
module mem_master #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRd,
  output logic        MemWr,
  output logic [31:0] Addr,
  output logic [31:0] W_data,
  input  logic [31:0] R_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_bad;
  logic        phase_done;

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{sgn & b[7]}}, b};
      2'b01:   res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] res;
    res = word;
    if (size == 2'b00) res[{off, 3'b000} +: 8] = wd[7:0];
    else               res[{off[1], 4'b0000} +: 16] = wd[15:0];
    return res;
  endfunction

  assign req_bad = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign phase_done = (cnt_q == LAST_CNT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          data_d   = req_wdata;
          rdata_d  = '0;
          err_d    = req_bad;
          cnt_d    = '0;
          if (req_bad)                          state_d = RESP;
          else if (req_we && req_size == 2'b10) state_d = WRITE;
          else                                  state_d = READ;
        end
      end
      READ: begin
        if (phase_done) begin
          cnt_d = '0;
          // Sub-word stores reuse the read phase to fetch the word they patch.
          if (we_q) begin
            data_d  = merge_store(R_data, addr_q[1:0], size_q, data_q);
            state_d = WRITE;
          end else begin
            rdata_d = extend_load(R_data, addr_q[1:0], size_q, signed_q);
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WRITE: begin
        if (phase_done) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Strobes decode straight from state so a reset drops them without waiting for a clock.
  assign req_ready  = (state_q == IDLE);
  assign MemRd      = (state_q == READ);
  assign MemWr      = (state_q == WRITE);
  assign Addr       = (MemRd || MemWr) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign W_data     = MemWr ? data_q : 32'd0;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master: a word-array reference model predicts every response and memory strobe.
module tb_mem_master;

  localparam int WC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        MemRd, MemWr;
  logic [31:0] Addr, W_data, R_data;

  mem_master #(.WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr), .W_data(W_data), .R_data(R_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory environment: 16 words at byte addresses 64..127.
  logic [31:0] mem [16] = '{default: 32'd0};
  assign R_data = MemRd ? mem[Addr[5:2]] : 32'hDEAD_BEEF;
  always @(posedge clk) if (MemWr) mem[Addr[5:2]] <= W_data;

  logic [31:0] ref_mem [16] = '{default: 32'd0};

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   nrd_seen = 0;
  int   nwr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                           input logic [1:0] size, input bit sgn);
    longint v;
    if (size == 2'd2) return w;
    if (size == 2'd0) begin
      v = longint'((w >> (8 * off)) & 32'hFF);
      if (sgn && v >= 128) v -= 256;
    end else begin
      v = longint'((w >> (8 * off)) & 32'hFFFF);
      if (sgn && v >= 32768) v -= 65536;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] w, input int off,
                                            input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] mask;
    mask = (size == 2'd0) ? 32'hFF : 32'hFFFF;
    return (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("protocol", {29'd0, MemRd & MemWr, !MemWr && W_data != 0,
                       !resp_valid && (resp_rdata != 0 || resp_err)}, 32'd0);
      if (MemRd || MemWr) begin
        if (sb.size() == 0) chk("strobe_without_request", 32'd1, 32'd0);
        else begin
          chk("Addr", Addr, sb[0].addr);
          if (MemWr) chk("W_data", W_data, sb[0].wdata);
        end
        if (MemRd) nrd_seen++;
        if (MemWr) nwr_seen++;
      end
      if (resp_valid) begin
        if (sb.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("resp_rdata", resp_rdata, mon_e.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
          chk("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
          chk("MemRd_cycles", 32'(nrd_seen), 32'(mon_e.nrd));
          chk("MemWr_cycles", 32'(nwr_seen), 32'(mon_e.nwr));
        end
        nrd_seen = 0;
        nwr_seen = 0;
      end
    end
  end

  task automatic issue(input bit we, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input bit wait_resp);
    exp_t        e;
    int          idx = int'(addr[5:2]);
    int          off = int'(addr[1:0]);
    logic [31:0] old = ref_mem[idx];
    bit          bad;
    int          t = 0;
    bad = (size == 2'd3) || (size == 2'd1 && off % 2 != 0) || (size == 2'd2 && off != 0);
    e.addr = {addr[31:2], 2'b00};
    e.err = bad; e.rdata = 0; e.nrd = 0; e.nwr = 0; e.wdata = 0; e.acc = 0;
    if (bad) e.lat = 1;
    else if (!we) begin
      e.nrd = WC; e.lat = WC + 1; e.rdata = ref_load(old, off, size, sgn);
    end else if (size == 2'd2) begin
      e.nwr = WC; e.lat = WC + 1; e.wdata = wd; ref_mem[idx] = wd;
    end else begin
      e.nrd = WC; e.nwr = WC; e.lat = 2 * WC + 1;
      e.wdata = ref_merge(old, off, size, wd); ref_mem[idx] = e.wdata;
    end
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (wait_resp) begin
      t = 0;
      while (sb.size() != 0 && t < 100) begin @(negedge clk); t++; end
      if (sb.size() != 0) begin
        chk("response_timeout", 32'd0, 32'd1);
        sb.delete();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #1;
    chk("reset_ready_valid", {30'd0, req_ready, resp_valid}, 32'd2);
    chk("reset_strobes", {30'd0, MemRd, MemWr}, 32'd0);
    chk("reset_Addr", Addr, 32'd0);
    chk("reset_W_data_rdata", W_data | resp_rdata | {31'd0, resp_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 1'b0, 32'(64 + 4 * i), $urandom, 1'b1);

    issue(1'b1, 2'd2, 1'b0, 32'd64, 32'h8899AABB, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'd64, 32'd0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'd66, 32'd0, 1'b1);
    issue(1'b0, 2'd0, 1'b0, 32'd66, 32'd0, 1'b1);
    issue(1'b0, 2'd1, 1'b1, 32'd64, 32'd0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'd64, 32'd10, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'd64, 32'd0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'd64, 32'h11223344, 1'b1);
    issue(1'b1, 2'd0, 1'b0, 32'd65, 32'hEE, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'd64, 32'd0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'd66, 32'd0, 1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'd64, 32'd0, 1'b1);
    issue(1'b1, 2'd1, 1'b0, 32'd67, 32'h1234, 1'b1);

    for (int i = 0; i < 300; i++)
      issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
            32'($urandom_range(64, 127)), $urandom, 1'b1);

    // Reset during the second WRITE cycle of a word store.
    issue(1'b1, 2'd2, 1'b0, 32'd68, 32'hCAFE_F00D, 1'b0);
    t = 0;
    while (!MemWr && t < 20) begin @(negedge clk); t++; end
    @(posedge clk);
    #2;
    chk("MemWr_before_reset", {31'd0, MemWr}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("MemWr_async_drop", {31'd0, MemWr}, 32'd0);
    chk("ready_in_reset", {30'd0, req_ready, resp_valid}, 32'd2);
    chk("Addr_in_reset", Addr | W_data, 32'd0);
    sb.delete();
    nrd_seen = 0;
    nwr_seen = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    issue(1'b0, 2'd2, 1'b0, 32'd68, 32'd0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'd71, 32'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001: Parameter WAIT_CYCLES, default 1, number of cycles each memory access phase holds MemRd or MemWr asserted; legal range 1..15.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: req_valid  input  1  datapath request present.
REQ-005: req_ready  output  1  block can accept a request.
REQ-006: req_we  input  1  1 = store, 0 = load.
REQ-007: req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008: req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009: req_addr  input  32  byte address.
REQ-010: req_wdata  input  32  store data, right-justified.
REQ-011: resp_valid  output  1  one-cycle completion pulse.
REQ-012: resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013: resp_err  output  1  misaligned or illegal-size request; valid with resp_valid.
REQ-014: MemRd  output  1  memory read strobe.
REQ-015: MemWr  output  1  memory write strobe.
REQ-016: Addr  output  32  word-aligned memory address.
REQ-017: W_data  output  32  memory write data.
REQ-018: R_data  input  32  memory read data, valid while MemRd is high.

Function
REQ-019: FSM states: IDLE, READ, WRITE, RESP.
REQ-020: req_ready = 1 only in IDLE; a request is accepted on a rising edge with req_valid & req_ready, and all request fields are registered at that edge.
REQ-021: Error check at acceptance: halfword with addr[0]=1, word with addr[1:0]!=00, or size=11 -> go to RESP; no MemRd/MemWr pulse; resp_err=1, resp_rdata=0.
REQ-022: Addr = {req_addr[31:2],2'b00}; driven from the registered address in READ and WRITE; 0 in IDLE and RESP.
REQ-023: Byte lanes are little-endian: byte offset 0 = data[7:0], offset 3 = data[31:24]; halfword offset 0 = [15:0], offset 2 = [31:16].
REQ-024: Load: IDLE -> READ; MemRd=1 for exactly WAIT_CYCLES cycles; R_data is captured on the edge ending the last READ cycle; -> RESP.
REQ-025: Load result: selected lane extended per req_signed; a word load returns R_data unchanged.
REQ-026: Word store: IDLE -> WRITE; MemWr=1 and W_data=req_wdata for exactly WAIT_CYCLES cycles; -> RESP.
REQ-027: Byte/halfword store is read-modify-write: READ (WAIT_CYCLES) -> WRITE (WAIT_CYCLES); W_data = captured word with only the target lane(s) replaced by the low bits of req_wdata.
REQ-028: RESP lasts exactly one cycle with resp_valid=1, then returns to IDLE; the next request can be accepted on the edge ending RESP.
REQ-029: Latencies (acceptance edge to resp_valid high): load WAIT_CYCLES+1 cycles; word store WAIT_CYCLES+1; sub-word store 2*WAIT_CYCLES+1; error 1.
REQ-030: MemRd and MemWr are never high in the same cycle; both are low in IDLE and RESP.
REQ-031: W_data = 0 whenever MemWr = 0.
REQ-032: resp_rdata, resp_err hold 0 whenever resp_valid = 0.
REQ-033: Changes to request inputs after acceptance have no effect on the current access.

Reset
REQ-034: While rst_n=0: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, MemRd=0, MemWr=0, Addr=0, W_data=0, all captured registers 0.
REQ-035: Reset asserted mid-access aborts immediately; no response is issued, and a WRITE in progress is dropped with MemWr falling asynchronously.

Verification
REQ-036: WAIT_CYCLES=1; memory word 64 = 0x8899AABB; load word, addr 64 -> MemRd high 1 cycle with Addr=64; resp_valid 2 cycles after acceptance; resp_rdata=0x8899AABB, resp_err=0.
REQ-037: Same memory; load byte signed, addr 66 -> resp_rdata=0xFFFFFF99; unsigned load -> 0x00000099; signed halfword load, addr 64 -> 0xFFFFAABB.
REQ-038: Word store 10 to addr 64 -> MemWr high 1 cycle, Addr=64, W_data=0x0000000A; memory then reads 0x0000000A; resp_valid 2 cycles after acceptance.
REQ-039: Memory word 64 = 0x11223344; store byte 0xEE to addr 65 -> READ then WRITE with W_data=0x1122EE44; resp_valid 3 cycles after acceptance.
REQ-040: Word load at addr 66 and req_size=11 -> no MemRd/MemWr; resp_valid next cycle with resp_err=1, resp_rdata=0.
REQ-041: WAIT_CYCLES=3; assert rst_n=0 during the 2nd WRITE cycle of a store -> MemWr drops immediately; no resp_valid; after release req_ready=1 and a new load completes normally.
